// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, oversampled by the system clock, CLKS_PER_BIT clocks per bit.
// Latency: data_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clks after i_bit is first sampled low.
// Backpressure: none; the byte is offered for one cycle and data_out holds it until the next good frame.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bit,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  // Two-flop synchronizer; both stages idle high so reset does not fake a start bit.
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  // pend: stop bit was good, deliver the byte on the next edge.
  // brk:  stop bit was bad, wait in STOP until the line returns high.
  logic          pend_q, pend_d;
  logic          brk_q, brk_d;

  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  // Next-state and output computation for the receive FSM.
  always_comb begin
    sync1_d      = i_bit;
    rx_s_d       = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    brk_d        = brk_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    // busy lags the state by one register so it drops the cycle after the valid strobe.
    busy_d       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        brk_d  = 1'b0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      START: begin
        // Recheck the line half a bit in; a high line here was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            idx_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        // Counter was zeroed at mid start bit, so every wrap lands mid data bit.
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (pend_q) begin
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          pend_d       = 1'b0;
          state_d      = IDLE;
        end else if (brk_q) begin
          // Hold off on a stuck-low line so a break is not decoded as a stream of 0x00 bytes.
          if (rx_s_q) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            pend_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset returns to an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      pend_q       <= 1'b0;
      brk_q        <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      brk_q        <= brk_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT = 16, 4 and 100.
// Stimulus pushes expected bytes / frame errors; a negedge monitor pops and compares.
// Bench drives serial lines directly; no backpressure exists on the receiver.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic [2:0] line;
  logic [7:0] dout [3];
  logic [2:0] dv;
  logic [2:0] fe;
  logic [2:0] bz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         k;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t exp_q [$];
  int   fe_q  [$];

  exp_t       mon_e;
  logic [2:0] dv_prev = 3'b000;
  logic [2:0] fe_prev = 3'b000;
  logic [2:0] after_dv = 3'b000;

  uart_rx #(.CLKS_PER_BIT(16)) u16 (
    .clk(clk), .rst(rst), .i_bit(line[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .frame_err(fe[0]), .busy(bz[0])
  );
  uart_rx #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .i_bit(line[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .frame_err(fe[1]), .busy(bz[1])
  );
  uart_rx #(.CLKS_PER_BIT(100)) u100 (
    .clk(clk), .rst(rst), .i_bit(line[2]), .data_out(dout[2]),
    .data_valid(dv[2]), .frame_err(fe[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int lat(input int c);
    return 2 + c / 2 + 9 * c + 1;
  endfunction

  // Called at a negedge; drives one full 8N1 frame and leaves the line at the stop value.
  task automatic send(input int k, input int c, input logic [7:0] b, input logic stop);
    exp_t e;
    if (stop) begin
      e.k   = k;
      e.dat = b;
      e.cyc = cyc + 1 + lat(c);
      exp_q.push_back(e);
    end else begin
      fe_q.push_back(k);
    end
    line[k] = 1'b0;
    repeat (c) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line[k] = b[i];
      repeat (c) @(negedge clk);
    end
    line[k] = stop;
    repeat (c) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output strobe.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dv[k] && fe[k]) chk("valid_and_ferr_together", 1, 0);
      if (dv[k]) begin
        if (dv_prev[k]) chk("valid_width", 2, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", k, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("valid_inst", k, mon_e.k);
          chk("valid_data", dout[k], mon_e.dat);
          chk("valid_latency", cyc, mon_e.cyc);
        end
        after_dv[k] = 1'b1;
      end else if (after_dv[k]) begin
        chk("busy_after_valid", bz[k], 0);
        after_dv[k] = 1'b0;
      end
      if (fe[k]) begin
        if (fe_prev[k]) chk("ferr_width", 2, 1);
        if (fe_q.size() == 0) chk("unexpected_ferr", k, 32'hFFFF_FFFF);
        else chk("ferr_inst", k, fe_q.pop_front());
      end
      dv_prev[k] = dv[k];
      fe_prev[k] = fe[k];
    end
  end

  initial begin
    int hi;
    int seen;
    rst  = 1'b1;
    line = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout[0], 8'h00);
    chk("rst_valid", dv[0], 0);
    chk("rst_ferr", fe[0], 0);
    chk("rst_busy", bz[0], 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // False start: 4-clk low glitch.
    hi = 0;
    seen = 0;
    line[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) line[0] = 1'b1;
      @(negedge clk);
      if (bz[0]) begin
        seen = 1;
        hi = hi + 1;
      end
    end
    chk("fs_busy_seen", seen, 1);
    chk("fs_busy_len_le10", (hi <= 10), 1);
    repeat (400) @(negedge clk);
    chk("fs_dout", dout[0], 8'h00);
    chk("fs_busy_idle", bz[0], 0);

    // Single byte.
    send(0, 16, 8'hA5, 1'b1);
    repeat (32) @(negedge clk);
    chk("a5_dout_hold", dout[0], 8'hA5);

    // Good byte, then a frame with a bad stop bit held low two more bit times.
    send(0, 16, 8'h3C, 1'b1);
    repeat (32) @(negedge clk);
    send(0, 16, 8'h81, 1'b0);
    repeat (32) @(negedge clk);
    chk("brk_busy_high", bz[0], 1);
    chk("brk_dout_kept", dout[0], 8'h3C);
    line[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("brk_busy_low", bz[0], 0);
    chk("brk_dout_after", dout[0], 8'h3C);
    repeat (16) @(negedge clk);

    // Back-to-back: second start bit follows the first stop bit with no gap.
    send(0, 16, 8'h00, 1'b1);
    send(0, 16, 8'hFF, 1'b1);
    repeat (32) @(negedge clk);
    chk("b2b_dout", dout[0], 8'hFF);

    // Reset in the middle of data bit 4 of 0x5A.
    line[0] = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line[0] = (i == 1 || i == 3);
      repeat (16) @(negedge clk);
    end
    line[0] = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_dout", dout[0], 8'h00);
    chk("midrst_busy", bz[0], 0);
    chk("midrst_valid", dv[0], 0);
    chk("midrst_ferr", fe[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle_busy", bz[0], 0);
    send(0, 16, 8'hC3, 1'b1);
    repeat (32) @(negedge clk);
    chk("midrst_c3", dout[0], 8'hC3);

    // Parameter sweep.
    send(1, 4, 8'h01, 1'b1);
    repeat (8) @(negedge clk);
    send(1, 4, 8'h80, 1'b1);
    repeat (8) @(negedge clk);
    chk("c4_dout", dout[1], 8'h80);
    send(2, 100, 8'h01, 1'b1);
    repeat (200) @(negedge clk);
    send(2, 100, 8'h80, 1'b1);
    repeat (200) @(negedge clk);
    chk("c100_dout", dout[2], 8'h80);

    chk("pending_valids", exp_q.size(), 0);
    chk("pending_ferrs", fe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that is the downstream counterpart of the UART transmitter.
- Consumes the asynchronous serial line (8N1 framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1)).
- Oversamples the line with the system clock, recovers each byte, and presents it with a one-cycle valid strobe.
- Flags framing errors; feeds the byte-consuming logic above the UART.

Parameters:
- CLKS_PER_BIT, 16, system clocks per serial bit period. Must be an even number ≥ 4.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- i_bit  input  1  serial line; idle high; asynchronous to clk
- data_out  output  8  last correctly received byte
- data_valid  output  1  one-clk pulse when data_out has just been updated
- frame_err  output  1  one-clk pulse when a stop bit is sampled as 0
- busy  output  1  high while a frame is in progress (state ≠ IDLE)

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, all registers clear.
- Output values during reset: data_out=8'h00, data_valid=0, frame_err=0, busy=0. State=IDLE, bit counter=0, clock counter=0, synchronizer flops=1 (line idle).
- Synchronizer: i_bit passes through a 2-flop synchronizer. All logic below uses the synchronized value, rx_s.
- State encoding: 2-bit state register. IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
- IDLE:
  - Clock counter is held at 0.
  - On the first cycle with rx_s=0, go to START.
- START:
  - Count CLKS_PER_BIT/2 clocks. Sample rx_s at that count (mid start bit).
  - rx_s=0: reset the clock counter, set the bit index to 0, go to DATA.
  - rx_s=1: false start (glitch). Return to IDLE with no output pulse.
- DATA:
  - Every CLKS_PER_BIT clocks, sample rx_s at mid-bit into shift[bit_index].
  - After the 8th sample (bit_index=7), go to STOP.
- STOP:
  - After CLKS_PER_BIT clocks, sample rx_s.
  - rx_s=1: on the next clk edge, data_out ← shift and data_valid=1 for exactly one cycle. Go to IDLE.
  - rx_s=0: frame_err=1 for exactly one cycle and data_out is unchanged. The block stays in STOP (busy=1) until rx_s=1 (break handling), then goes to IDLE.
- Latency: data_valid rises exactly 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 clks after the first clk edge that samples i_bit low. For CLKS_PER_BIT=16 this is 155 clks.
- Pulse exclusivity: data_valid and frame_err are never high in the same cycle. Neither is ever high for more than one cycle.
- Back-to-back frames: a new start bit may begin as early as the first clk after the stop-bit mid-sample. IDLE detects it on its first cycle, so no frame is lost when the gap between frames is 0 stop-bit remainder.
- Counters: the clock counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at each sample point. The bit index is 3 bits.
- Reset mid-frame: takes effect immediately (asynchronous) with no output pulse. After release, the block waits for a fresh falling edge. A partially received frame is never delivered.
- data_out holds its value indefinitely between valid frames.

Test Plan:
- Single byte, CLKS_PER_BIT=16: drive 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1). Required: data_out=0xA5, data_valid high for 1 cycle at 155±0 clks after the start edge, frame_err=0 throughout, busy falls in the cycle after the valid pulse.
- False start: pulse i_bit low for 4 clks, then hold high for 400 clks. Required: no data_valid, no frame_err, busy returns to 0 within 8+2 clks, data_out stays 0x00.
- Framing error: receive 0x3C correctly, then send 0x81 with stop bit=0, held low for 2 extra bit times. Required: frame_err pulses once, data_out stays 0x3C, busy=1 until the line returns high, then 0.
- Back-to-back: send 0x00 then immediately 0xFF, with the second start bit starting at the exact end of the first stop bit. Required: two data_valid pulses exactly 160 clks apart, with values 0x00 then 0xFF.
- Reset mid-frame: assert rst at data bit 4 of 0x5A for 3 clks, then send 0xC3. Required: outputs clear during reset; only one data_valid, with data_out=0xC3.
- Parameter sweep: CLKS_PER_BIT=4 and 100 with bytes 0x01 and 0x80. Required: correct bytes, and latency matches the formula.
